svm_ai_sequencer: RTL and testbench

- Controller for the Gaussian-kernel Ai accumulation datapath in the SVM classifier.
- For one test sample, it walks every support vector i. For each vector it issues NUM_GRP feature-group addresses, then waits for the datapath's sop_Ai / Ai result.
- It folds each Ai into a sign-magnitude decision accumulator seeded with a bias, and produces the final class label.
- Sits between the top-level classification control and the Ai datapath. It also drives the datapath's svm_i, z_j and address_z inputs.

---
 rtl/svm_ai_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_svm_ai_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/svm_ai_sequencer.sv
// Sequencer for the Gaussian-kernel Ai accumulation: issues feature-group addresses per
// support vector, folds each Ai into a sign-magnitude decision accumulator, emits the label.
module svm_ai_sequencer #(
    parameter int NUM_SV  = 800,
    parameter int NUM_GRP = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] sample_base,
    input  logic [31:0] bias,
    output logic [17:0] address_z,
    output logic [9:0]  z_j,
    output logic [9:0]  svm_i,
    output logic        issue,
    input  logic        sop_Ai,
    input  logic [31:0] Ai,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] decision,
    output logic        class_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_ACC, S_NEXT, S_FIN
    } state_t;

    state_t      state_q;
    logic [17:0] base_q;
    logic [31:0] acc_q;
    logic [31:0] ai_q;
    logic [9:0]  j_q;
    logic [7:0]  tcnt_q;
    logic [17:0] addr_q;
    logic [9:0]  zj_q;
    logic [9:0]  svi_q;
    logic        issue_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] dec_q;
    logic        cls_q;

    logic [9:0]  j_d;
    logic [31:0] acc_d;

    function automatic logic [29:0] sat30(input logic [30:0] sum);
        return sum[30] ? 30'h3FFF_FFFF : sum[29:0];
    endfunction

    // Codes 10/11 mean zero; they load as positive zero so the accumulator is always 0x.
    function automatic logic [31:0] load_bias(input logic [31:0] b);
        return b[31] ? 32'h0000_0000 : b;
    endfunction

    function automatic logic [31:0] sm_add(input logic [31:0] a, input logic [31:0] b);
        logic [29:0] ma;
        logic [29:0] mb;
        ma = a[29:0];
        mb = b[29:0];
        if (b[31])
            return a;
        if (a[30] == b[30])
            return {1'b0, a[30], sat30({1'b0, ma} + {1'b0, mb})};
        if (ma > mb)
            return {1'b0, a[30], ma - mb};
        if (mb > ma)
            return {1'b0, b[30], mb - ma};
        return 32'h0000_0000;
    endfunction

    function automatic logic is_positive(input logic [31:0] a);
        return (a[31:30] == 2'b00) && (a[29:0] != 30'd0);
    endfunction

    assign j_d   = j_q + 10'd1;
    assign acc_d = sm_add(acc_q, ai_q);

    // Datapath registers carry no reset; they are always written before being consumed.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            base_q <= sample_base;
            acc_q  <= load_bias(bias);
        end else if (state_q == S_ACC) begin
            acc_q  <= acc_d;
        end
        if (state_q == S_WAIT && sop_Ai)
            ai_q <= Ai;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            tcnt_q  <= '0;
            addr_q  <= '0;
            zj_q    <= '0;
            svi_q   <= '0;
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dec_q   <= 32'h8000_0000;
            cls_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ISSUE;
                        j_q     <= '0;
                        zj_q    <= '0;
                        svi_q   <= '0;
                        addr_q  <= sample_base;
                        issue_q <= 1'b1;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (j_q == 10'(NUM_GRP - 1)) begin
                        state_q <= S_WAIT;
                        issue_q <= 1'b0;
                        tcnt_q  <= '0;
                    end else begin
                        j_q    <= j_d;
                        zj_q   <= j_d;
                        addr_q <= base_q + {8'd0, j_d};
                    end
                end
                S_WAIT: begin
                    if (sop_Ai) begin
                        state_q <= S_ACC;
                    end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                        // Timeout: publish the partial sum with err raised.
                        state_q <= S_FIN;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        dec_q   <= acc_q;
                        cls_q   <= is_positive(acc_q);
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                S_ACC: begin
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (svi_q == 10'(NUM_SV - 1)) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                        dec_q   <= acc_q;
                        cls_q   <= is_positive(acc_q);
                    end else begin
                        state_q <= S_ISSUE;
                        svi_q   <= svi_q + 10'd1;
                        j_q     <= '0;
                        zj_q    <= '0;
                        addr_q  <= base_q;
                        issue_q <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign address_z = addr_q;
    assign z_j       = zj_q;
    assign svm_i     = svi_q;
    assign issue     = issue_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign decision  = dec_q;
    assign class_out = cls_q;

endmodule

// File: tb/tb_svm_ai_sequencer.sv
// Directed bench for svm_ai_sequencer: three vectors of two groups, timeout of 16 cycles.
module tb_svm_ai_sequencer;

    localparam int NSV  = 3;
    localparam int NGRP = 2;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [17:0] sample_base;
    logic [31:0] bias;
    logic [17:0] address_z;
    logic [9:0]  z_j;
    logic [9:0]  svm_i;
    logic        issue;
    logic        sop_Ai;
    logic [31:0] Ai;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] decision;
    logic        class_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations captured by run_txn
    logic [17:0] addr_log [16];
    logic [9:0]  zj_log   [16];
    logic [9:0]  sv_log   [16];
    int          n_issue;
    int          n_done;
    int          done_cyc;
    int          wait_entry;
    logic [31:0] dec_at_done;
    logic        cls_at_done;
    logic        err_at_done;
    logic [31:0] dec_late;
    logic        busy_after;
    logic        busy_after2;

    svm_ai_sequencer #(.NUM_SV(NSV), .NUM_GRP(NGRP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .sample_base(sample_base), .bias(bias),
        .address_z(address_z), .z_j(z_j), .svm_i(svm_i), .issue(issue),
        .sop_Ai(sop_Ai), .Ai(Ai), .busy(busy), .done(done), .err(err),
        .decision(decision), .class_out(class_out)
    );

    always #5 clk = ~clk;

    // Datapath model: answers each vector 7 cycles after its last issue, for the first nresp vectors.
    task automatic run_txn(input logic [31:0] b, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input int nresp, input bit rob, input bit fin_start);
        logic [31:0] ai_v [3];
        int vec, cnt, cyc, post;
        bit armed, got;
        ai_v[0] = a0; ai_v[1] = a1; ai_v[2] = a2;
        n_issue = 0; n_done = 0; done_cyc = -1; wait_entry = -1;
        vec = 0; cnt = 0; cyc = 0; post = 0; armed = 0; got = 0;
        busy_after = 1'b1; busy_after2 = 1'b1; dec_late = 32'hxxxx_xxxx;
        @(negedge clk);
        bias = b; sample_base = 18'd100; start = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            cyc++;
            start  = 1'b0;
            sop_Ai = 1'b0;
            if (got) begin
                post++;
                if (post == 1) busy_after = busy;
                if (post == 2) busy_after2 = busy;
                if (post == 3) begin dec_late = decision; break; end
            end
            if (issue) begin
                if (n_issue < 16) begin
                    addr_log[n_issue] = address_z; zj_log[n_issue] = z_j; sv_log[n_issue] = svm_i;
                end
                n_issue++;
                if (rob) begin start = 1'b1; sop_Ai = 1'b1; Ai = 32'h0000_1000; end
                if (z_j == 10'(NGRP - 1)) begin armed = 1; cnt = 0; wait_entry = cyc + 1; end
            end else if (armed) begin
                cnt++;
                if (cnt == 7) begin
                    armed = 0;
                    if (vec < nresp) begin sop_Ai = 1'b1; Ai = ai_v[vec]; vec++; end
                end
            end
            if (done) begin
                n_done++;
                if (!got) begin
                    got = 1; done_cyc = cyc;
                    dec_at_done = decision; cls_at_done = class_out; err_at_done = err;
                    if (fin_start) start = 1'b1;
                end
            end
        end
        start = 1'b0; sop_Ai = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sop_Ai = 1'b0; Ai = '0; bias = '0; sample_base = '0;
        #12;
        n_cmp++; if ({busy, done, err, issue, class_out} !== 5'b0) begin n_bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, issue, class_out}); end
        n_cmp++; if (decision !== 32'h8000_0000) begin n_bad++;
            $display("FAIL reset_decision: got %h want 80000000", decision); end
        n_cmp++; if ({address_z, z_j, svm_i} !== 38'd0) begin n_bad++;
            $display("FAIL reset_addr: got %h want 0", {address_z, z_j, svm_i}); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_main;
        run_txn(32'h0000_0005, 32'h0000_000A, 32'h4000_0003, 32'h0000_0001, 3, 0, 1);
        n_cmp++; if (n_issue !== 6) begin n_bad++; $display("FAIL main_issues: got %0d want 6", n_issue); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (addr_log[i] !== 18'(100 + i % 2)) begin n_bad++;
                $display("FAIL main_addr[%0d]: got %0d want %0d", i, addr_log[i], 100 + i % 2); end
            n_cmp++; if (zj_log[i] !== 10'(i % 2)) begin n_bad++;
                $display("FAIL main_zj[%0d]: got %0d want %0d", i, zj_log[i], i % 2); end
            n_cmp++; if (sv_log[i] !== 10'(i / 2)) begin n_bad++;
                $display("FAIL main_svm_i[%0d]: got %0d want %0d", i, sv_log[i], i / 2); end
        end
        n_cmp++; if (dec_at_done !== 32'h0000_000D) begin n_bad++;
            $display("FAIL main_decision: got %h want 0000000D", dec_at_done); end
        n_cmp++; if (cls_at_done !== 1'b1) begin n_bad++; $display("FAIL main_class: got %b want 1", cls_at_done); end
        n_cmp++; if (err_at_done !== 1'b0) begin n_bad++; $display("FAIL main_err: got %b want 0", err_at_done); end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL main_done_pulses: got %0d want 1", n_done); end
        n_cmp++; if (busy_after !== 1'b0 || busy_after2 !== 1'b0) begin n_bad++;
            $display("FAIL start_in_fin: got busy %b%b want 00", busy_after, busy_after2); end
        n_cmp++; if (dec_late !== 32'h0000_000D) begin n_bad++;
            $display("FAIL main_decision_hold: got %h want 0000000D", dec_late); end
    endtask

    task automatic test_cancel;
        run_txn(32'h0000_0008, 32'h4000_0008, 32'h8000_0000, 32'hC000_0000, 3, 0, 0);
        n_cmp++; if (dec_at_done !== 32'h0000_0000 || cls_at_done !== 1'b0) begin n_bad++;
            $display("FAIL cancel: got %h/%b want 00000000/0", dec_at_done, cls_at_done); end
    endtask

    task automatic test_sign_flip;
        run_txn(32'h0000_0002, 32'h4000_0005, 32'h8000_0000, 32'h4000_0001, 3, 0, 0);
        n_cmp++; if (dec_at_done !== 32'h4000_0004 || cls_at_done !== 1'b0) begin n_bad++;
            $display("FAIL sign_flip: got %h/%b want 40000004/0", dec_at_done, cls_at_done); end
    endtask

    task automatic test_bias_zero_code;
        run_txn(32'h8000_0123, 32'h4000_0003, 32'h0000_0001, 32'h0000_0001, 3, 0, 0);
        n_cmp++; if (dec_at_done !== 32'h4000_0001 || cls_at_done !== 1'b0) begin n_bad++;
            $display("FAIL bias_zero_code: got %h/%b want 40000001/0", dec_at_done, cls_at_done); end
    endtask

    task automatic test_timeout;
        run_txn(32'h0000_0005, 32'h0000_000A, 32'h0000_0000, 32'h0000_0000, 1, 0, 0);
        n_cmp++; if (err_at_done !== 1'b1 || n_done !== 1) begin n_bad++;
            $display("FAIL timeout_err: got err %b done %0d want 1/1", err_at_done, n_done); end
        n_cmp++; if (done_cyc - wait_entry !== TMO) begin n_bad++;
            $display("FAIL timeout_latency: got %0d want %0d", done_cyc - wait_entry, TMO); end
        n_cmp++; if (dec_at_done !== 32'h0000_000F || n_issue !== 4) begin n_bad++;
            $display("FAIL timeout_partial: got %h issues %0d want 0000000F/4", dec_at_done, n_issue); end
    endtask

    task automatic test_saturation;
        run_txn(32'h3FFF_FFF0, 32'h0000_0100, 32'h8000_0000, 32'h8000_0000, 3, 0, 0);
        n_cmp++; if (dec_at_done !== 32'h3FFF_FFFF || cls_at_done !== 1'b1) begin n_bad++;
            $display("FAIL saturation: got %h/%b want 3FFFFFFF/1", dec_at_done, cls_at_done); end
        n_cmp++; if (err_at_done !== 1'b0) begin n_bad++;
            $display("FAIL err_cleared: got %b want 0", err_at_done); end
    endtask

    task automatic test_robustness;
        run_txn(32'h0000_0005, 32'h0000_000A, 32'h4000_0003, 32'h0000_0001, 3, 1, 0);
        n_cmp++; if (dec_at_done !== 32'h0000_000D || n_issue !== 6 || n_done !== 1) begin n_bad++;
            $display("FAIL robustness: got %h issues %0d done %0d want 0000000D/6/1", dec_at_done, n_issue, n_done); end
    endtask

    task automatic test_reset_mid;
        int st;
        int nd;
        st = 0; nd = 0;
        @(negedge clk);
        bias = 32'h0000_0005; sample_base = 18'd100; start = 1'b1;
        for (int k = 0; k < 50 && st < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (st == 0 && issue) st = 1;
            else if (st == 1 && !issue) st = 2;
        end
        n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL reset_mid_reach_wait: got %0d want 2", st); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || decision !== 32'h8000_0000 || done !== 1'b0) begin n_bad++;
            $display("FAIL reset_mid: got busy %b dec %h done %b want 0/80000000/0", busy, decision, done); end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            sop_Ai = (k == 3);
            Ai = 32'h0000_0007;
            if (done) nd++;
            if (busy) nd++;
        end
        sop_Ai = 1'b0;
        n_cmp++; if (nd !== 0 || decision !== 32'h8000_0000) begin n_bad++;
            $display("FAIL reset_mid_quiet: got activity %0d dec %h want 0/80000000", nd, decision); end
    endtask

    initial begin
        test_reset;
        test_main;
        test_cancel;
        test_sign_flip;
        test_bias_zero_code;
        test_timeout;
        test_saturation;
        test_robustness;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
